cache_flush_sequencer: RTL

CACHE_FLUSH_SEQUENCER -- requirements
Module: cache_flush_sequencer

---
 rtl/cache_flush_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/cache_flush_sequencer.sv
// Sequences a fence.i flush: DCache writeback/invalidate first, then ICache
// invalidate, with a per-state timeout that aborts to DONE and flags an error.
module cache_flush_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic flushReq,
    output logic flushAck,
    output logic flushBusy,
    output logic dcFlushReq,
    input  logic dcFlushReqAck,
    input  logic dcFlushComplete,
    output logic icFlushReq,
    input  logic icFlushReqAck,
    input  logic icFlushComplete,
    output logic flushComplete,
    output logic flushError
);

    localparam int          CNT_W     = 16;
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;
    localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DC_REQ  = 3'd1,
        DC_WAIT = 3'd2,
        IC_REQ  = 3'd3,
        IC_WAIT = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;
    logic               err_r;
    logic               err_s;
    logic               timeout_s;
    logic               in_timed_state_s;

    // A stuck cache holds the sequencer at most TIMEOUT_CYCLES in one state.
    assign timeout_s = (cnt_r >= CNT_LIMIT);

    // State, timeout counter and error flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            err_r   <= err_s;
        end
    end

    // Next-state selection; a completion seen in the timeout cycle still wins.
    always_comb begin
        state_s = state_r;
        err_s   = err_r;
        case (state_r)
            IDLE: begin
                if (flushReq) begin
                    state_s = DC_REQ;
                    err_s   = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            DC_REQ: begin
                if (dcFlushComplete) begin
                    state_s = IC_REQ;
                end else if (dcFlushReqAck) begin
                    state_s = DC_WAIT;
                end else if (timeout_s) begin
                    state_s = DONE;
                    err_s   = 1'b1;
                end else begin
                    state_s = DC_REQ;
                end
            end
            DC_WAIT: begin
                if (dcFlushComplete) begin
                    state_s = IC_REQ;
                end else if (timeout_s) begin
                    state_s = DONE;
                    err_s   = 1'b1;
                end else begin
                    state_s = DC_WAIT;
                end
            end
            IC_REQ: begin
                if (icFlushComplete) begin
                    state_s = DONE;
                end else if (icFlushReqAck) begin
                    state_s = IC_WAIT;
                end else if (timeout_s) begin
                    state_s = DONE;
                    err_s   = 1'b1;
                end else begin
                    state_s = IC_REQ;
                end
            end
            IC_WAIT: begin
                if (icFlushComplete) begin
                    state_s = DONE;
                end else if (timeout_s) begin
                    state_s = DONE;
                    err_s   = 1'b1;
                end else begin
                    state_s = IC_WAIT;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                err_s   = 1'b0;
            end
        endcase
    end

    // Only the request and wait states are timed.
    always_comb begin
        case (state_r)
            DC_REQ, DC_WAIT, IC_REQ, IC_WAIT: in_timed_state_s = 1'b1;
            default:                          in_timed_state_s = 1'b0;
        endcase
    end

    // Counter restarts on every transition and saturates instead of wrapping.
    always_comb begin
        cnt_s = cnt_r;
        if (state_s != state_r) begin
            cnt_s = '0;
        end else if (!in_timed_state_s) begin
            cnt_s = '0;
        end else if (cnt_r != CNT_MAX) begin
            cnt_s = cnt_r + 16'd1;
        end else begin
            cnt_s = cnt_r;
        end
    end

    // The accept is gated by rst so the core never sees an ack while reset is held.
    assign flushAck      = rst && (state_r == IDLE) && flushReq;
    assign flushBusy     = (state_r != IDLE);
    assign dcFlushReq    = (state_r == DC_REQ);
    assign icFlushReq    = (state_r == IC_REQ);
    assign flushComplete = (state_r == DONE);
    assign flushError    = err_r && (state_r == DONE);

endmodule
